// File: rtl/game_link_pkg.sv
// Shared definitions for the game-state UART link (transmitter now, receiver later).
// GAME_LINK_CHECKSUM_EN selects the 5-byte packet with a trailing XOR checksum.
package game_link_pkg;

  localparam logic [7:0] LINK_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    START_SCREEN = 2'b00,
    GAME         = 2'b01,
    GAME_END     = 2'b10
  } game_state_t;

  localparam int LINK_PKT_LEN_CHK   = 5;
  localparam int LINK_PKT_LEN_NOCHK = 4;

`ifdef GAME_LINK_CHECKSUM_EN
  localparam int LINK_PKT_LEN = LINK_PKT_LEN_CHK;
`else
  localparam int LINK_PKT_LEN = LINK_PKT_LEN_NOCHK;
`endif

  typedef enum logic [1:0] {
    SER_IDLE  = 2'b00,
    SER_START = 2'b01,
    SER_DATA  = 2'b10,
    SER_STOP  = 2'b11
  } ser_state_t;

  typedef enum logic [1:0] {
    LNK_IDLE = 2'b00,
    LNK_LOAD = 2'b01,
    LNK_SEND = 2'b10
  } link_state_t;

  function automatic logic [7:0] link_chk(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start request during the last stop cycle chains the next byte gap-free.
//  state     | meaning
//  SER_IDLE  | line high, waiting for i_start
//  SER_START | start bit (0)
//  SER_DATA  | data bits, LSB first
//  SER_STOP  | stop bit (1); o_byte_done on its last cycle
module uart_tx_byte
  import game_link_pkg::*;
#(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_byte_done
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  ser_state_t    r_state, w_state_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_data, w_data_nx;
  logic          r_tx, w_tx_nx;
  logic          w_tc;

  assign w_tc = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= SER_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_bit   <= w_bit_nx;
      r_data  <= w_data_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_baud_nx   = r_baud;
    w_bit_nx    = r_bit;
    w_data_nx   = r_data;
    o_byte_done = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (i_start) begin
          w_state_nx = SER_START;
          w_baud_nx  = '0;
          w_data_nx  = i_data;
        end
      end
      SER_START: begin
        if (w_tc) begin
          w_state_nx = SER_DATA;
          w_baud_nx  = '0;
          w_bit_nx   = '0;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      SER_DATA: begin
        if (w_tc) begin
          w_baud_nx = '0;
          if (r_bit == 3'd7) w_state_nx = SER_STOP;
          else               w_bit_nx   = r_bit + 3'd1;
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      SER_STOP: begin
        if (w_tc) begin
          o_byte_done = 1'b1;
          w_baud_nx   = '0;
          if (i_start) begin
            w_state_nx = SER_START;
            w_data_nx  = i_data;
          end else begin
            w_state_nx = SER_IDLE;
          end
        end else begin
          w_baud_nx = r_baud + 1'b1;
        end
      end
      default: w_state_nx = SER_IDLE;
    endcase

    // Line level follows the next state so tx leaves a flop with no input path.
    case (w_state_nx)
      SER_START: w_tx_nx = 1'b0;
      SER_DATA:  w_tx_nx = w_data_nx[w_bit_nx];
      default:   w_tx_nx = 1'b1;
    endcase
  end

  assign o_tx = r_tx;

endmodule

// File: rtl/game_link_tx.sv
// Game-state packet transmitter: captures status/score/bullets and sends SYNC,STATUS,SCORE,BULLETS.
// GAME_LINK_CHECKSUM_EN appends CHK = STATUS ^ SCORE ^ BULLETS.
//  state    | meaning
//  LNK_IDLE | waiting for send_req; inputs captured on acceptance
//  LNK_LOAD | hands the SYNC byte to the serializer
//  LNK_SEND | feeds the next byte on each byte_done until the packet ends
module game_link_tx
  import game_link_pkg::*;
#(
  parameter int CLK_FREQ = 40_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [1:0] game_state,
  input  logic [6:0] my_score,
  input  logic [6:0] bullets_left,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int PKT_LEN  = LINK_PKT_LEN;

  link_state_t r_state, w_state_nx;
  logic [2:0]  r_idx, w_idx_nx;
  logic [1:0]  r_status;
  logic [6:0]  r_score, r_bullets;
  logic        r_done, w_done_nx;
  logic        w_capture, w_start, w_byte_done;
  logic [7:0]  w_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= LNK_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_status  <= '0;
      r_score   <= '0;
      r_bullets <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_done  <= w_done_nx;
      if (w_capture) begin
        r_status  <= game_state;
        r_score   <= my_score;
        r_bullets <= bullets_left;
      end
    end
  end

  // r_idx always points at the byte the serializer will take next.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_capture  = 1'b0;
    w_start    = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      LNK_IDLE: begin
        if (send_req) begin
          w_capture  = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = LNK_LOAD;
        end
      end
      LNK_LOAD: begin
        w_start    = 1'b1;
        w_idx_nx   = r_idx + 3'd1;
        w_state_nx = LNK_SEND;
      end
      LNK_SEND: begin
        if (w_byte_done) begin
          if (r_idx == 3'(PKT_LEN)) begin
            w_state_nx = LNK_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_start  = 1'b1;
            w_idx_nx = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nx = LNK_IDLE;
    endcase
  end

  always_comb begin
    w_byte = LINK_SYNC;
    case (r_idx)
      3'd1:    w_byte = {6'b0, r_status};
      3'd2:    w_byte = {1'b0, r_score};
      3'd3:    w_byte = {1'b0, r_bullets};
`ifdef GAME_LINK_CHECKSUM_EN
      3'd4:    w_byte = link_chk({6'b0, r_status}, {1'b0, r_score}, {1'b0, r_bullets});
`endif
      default: w_byte = LINK_SYNC;
    endcase
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_data     (w_byte),
    .o_tx       (tx),
    .o_byte_done(w_byte_done)
  );

  assign busy = (r_state != LNK_IDLE);
  assign done = r_done;

endmodule
